// File: rtl/sha256_padder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sha256_padder_if                                              |
// | Desc     : Message-word input and 512-bit block output bundle of the     |
// |            SHA-256 padder. slave = padder side, master = source/core.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface sha256_padder_if;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;

    modport master (
        output in_valid, in_data, in_last, in_bytes, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_first, blk_last
    );

    modport slave (
        input  in_valid, in_data, in_last, in_bytes, blk_ready,
        output in_ready, blk_valid, blk_data, blk_first, blk_last
    );
endinterface
`default_nettype wire

// File: rtl/sha256_padder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sha256_padder                                                 |
// | Desc     : FIPS 180-4 message padder; packs 32-bit words into 512-bit    |
// |            blocks with 0x80 marker, zero fill and 64-bit bit length.     |
// |            Define SHA256_PAD_BYTESWAP_EN for little-endian input words.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sha256_padder (
    input  wire            clk,
    input  wire            reset,
    sha256_padder_if.slave bus
);

    typedef enum logic [2:0] {
        S_FILL = 3'd0,
        S_FULL = 3'd1,
        S_PAD  = 3'd2,
        S_LEN  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    localparam logic [31:0] c_marker_word = 32'h8000_0000;

    state_t       r_state;
    state_t       w_state_next;
    logic [3:0]   r_widx;
    logic [3:0]   w_widx_next;
    logic [60:0]  r_count;
    logic [60:0]  w_count_next;
    logic         r_marker;
    logic         w_marker_next;
    logic         r_pad_active;
    logic         w_pad_active_next;
    logic         r_first;
    logic         w_first_next;
    logic [511:0] r_buf;

    logic         w_wr_en;
    logic [31:0]  w_wr_word;
    logic         w_len_wr;
    logic         w_clear;
    logic [8:0]   w_wr_lsb;

    logic [31:0]  w_data;
    logic [31:0]  w_tail_word;
    logic [2:0]   w_nbytes;
    logic [3:0]   w_pad_slot;
    logic         w_accept;
    logic         w_blk_valid;
    logic         w_blk_hs;

`ifdef SHA256_PAD_BYTESWAP_EN
    assign w_data = {bus.in_data[7:0], bus.in_data[15:8],
                     bus.in_data[23:16], bus.in_data[31:24]};
`else
    assign w_data = bus.in_data;
`endif

    // in_bytes only matters on the final word; out-of-range counts clamp to a full word
    assign w_nbytes   = (!bus.in_last || (bus.in_bytes >= 3'd4)) ? 3'd4 : bus.in_bytes;
    assign w_pad_slot = (w_nbytes == 3'd0) ? r_widx : (r_widx + 4'd1);
    assign w_wr_lsb   = {4'd15 - r_widx, 5'd0};

    assign w_accept    = bus.in_valid && (r_state == S_FILL);
    assign w_blk_valid = (r_state == S_FULL) || (r_state == S_OUT);
    assign w_blk_hs    = w_blk_valid && bus.blk_ready;

    assign bus.in_ready  = (r_state == S_FILL) && !reset;
    assign bus.blk_valid = w_blk_valid;
    assign bus.blk_first = w_blk_valid && r_first;
    assign bus.blk_last  = (r_state == S_OUT);
    assign bus.blk_data  = r_buf;

    // Final partial word: keep the valid leading bytes, marker right after them
    always_comb begin
        w_tail_word = w_data;
        case (w_nbytes)
            3'd1:    w_tail_word = {w_data[31:24], 8'h80, 16'h0000};
            3'd2:    w_tail_word = {w_data[31:16], 8'h80, 8'h00};
            3'd3:    w_tail_word = {w_data[31:8],  8'h80};
            default: w_tail_word = w_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_widx_next       = r_widx;
        w_count_next      = r_count;
        w_marker_next     = r_marker;
        w_pad_active_next = r_pad_active;
        w_first_next      = r_first;
        w_wr_en           = 1'b0;
        w_wr_word         = '0;
        w_len_wr          = 1'b0;
        w_clear           = 1'b0;

        case (r_state)
            S_FILL: begin
                if (w_accept) begin
                    w_count_next = r_count + {58'd0, w_nbytes};
                    if (!bus.in_last) begin
                        w_wr_en   = 1'b1;
                        w_wr_word = w_data;
                        if (r_widx == 4'd15) begin
                            w_state_next = S_FULL;
                        end else begin
                            w_widx_next = r_widx + 4'd1;
                        end
                    end else begin
                        w_pad_active_next = 1'b1;
                        w_wr_en           = (w_nbytes != 3'd0);
                        w_wr_word         = w_tail_word;
                        w_marker_next     = (w_nbytes == 3'd4) || (w_nbytes == 3'd0);
                        if ((w_nbytes != 3'd0) && (r_widx == 4'd15)) begin
                            w_state_next = S_FULL;
                        end else if ((w_pad_slot == 4'd14) && !w_marker_next) begin
                            // marker already placed in slot 13: length fits in this block
                            w_state_next = S_LEN;
                        end else begin
                            w_state_next = S_PAD;
                            w_widx_next  = w_pad_slot;
                        end
                    end
                end
            end

            S_PAD: begin
                w_wr_en       = 1'b1;
                w_wr_word     = r_marker ? c_marker_word : 32'h0;
                w_marker_next = 1'b0;
                case (r_widx)
                    4'd13:   w_state_next = S_LEN;
                    4'd15:   w_state_next = S_FULL;
                    default: w_widx_next  = r_widx + 4'd1;
                endcase
            end

            S_LEN: begin
                w_len_wr     = 1'b1;
                w_state_next = S_OUT;
            end

            S_FULL: begin
                if (w_blk_hs) begin
                    w_clear      = 1'b1;
                    w_widx_next  = 4'd0;
                    w_first_next = 1'b0;
                    w_state_next = r_pad_active ? S_PAD : S_FILL;
                end
            end

            S_OUT: begin
                if (w_blk_hs) begin
                    w_clear           = 1'b1;
                    w_widx_next       = 4'd0;
                    w_count_next      = '0;
                    w_first_next      = 1'b1;
                    w_pad_active_next = 1'b0;
                    w_marker_next     = 1'b0;
                    w_state_next      = S_FILL;
                end
            end

            default: begin
                w_state_next = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_widx       <= 4'd0;
            r_count      <= '0;
            r_marker     <= 1'b0;
            r_pad_active <= 1'b0;
            r_first      <= 1'b1;
            r_buf        <= '0;
        end else begin
            r_widx       <= w_widx_next;
            r_count      <= w_count_next;
            r_marker     <= w_marker_next;
            r_pad_active <= w_pad_active_next;
            r_first      <= w_first_next;
            // Clearing on handshake makes every unwritten slot of the next block read 0
            if (w_clear) begin
                r_buf <= '0;
            end else begin
                if (w_wr_en) begin
                    r_buf[w_wr_lsb +: 32] <= w_wr_word;
                end
                if (w_len_wr) begin
                    r_buf[63:0] <= {r_count, 3'b000};
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_padder.sv
`default_nettype none
// Self-checking bench for sha256_padder: directed vector table, hand sequences
// for latency/hold/reset corners, and random messages against a byte-level model.
module tb_sha256_padder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sha256_padder_if bus();

    sha256_padder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [511:0] data;
        logic         first;
        logic         last;
    } blk_t;

    typedef struct {
        int          len;
        bit          tail0;
        int          nblk;
        logic [31:0] w15;
        int          cblk;
        int          cword;
        logic [31:0] cval;
    } vec_t;

    int         n_vec = 0;
    int         n_err = 0;
    bit         stuck = 1'b0;
    int         ready_pct = 100;
    int         gap_pct = 0;
    logic [7:0] msg[$];
    blk_t       exp_q[$];
    blk_t       rx_q[$];
    vec_t       tbl[12];

`ifdef SHA256_PAD_BYTESWAP_EN
    localparam logic [31:0] ABC_WORD = 32'h0063_6261;
`else
    localparam logic [31:0] ABC_WORD = 32'h6162_6300;
`endif

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [511:0] b, input int i);
        return b[(15 - i) * 32 +: 32];
    endfunction

    // Reference: pad the byte string, then cut into 64-byte blocks
    task automatic build_model();
        logic [7:0]  p[$];
        logic [63:0] bl;
        blk_t        b;
        int          nb;
        exp_q.delete();
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bl[8 * i +: 8]);
        nb = p.size() / 64;
        for (int k = 0; k < nb; k++) begin
            b.data = '0;
            for (int j = 0; j < 64; j++) b.data[511 - 8 * j -: 8] = p[64 * k + j];
            b.first = (k == 0);
            b.last  = (k == nb - 1);
            exp_q.push_back(b);
        end
    endtask

    function automatic logic [31:0] pack_word(input int base, input int nb);
        logic [31:0] w;
        w = $urandom;
        for (int j = 0; j < nb; j++) w[31 - 8 * j -: 8] = msg[base + j];
`ifdef SHA256_PAD_BYTESWAP_EN
        w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
        return w;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic drive_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int guard;
        guard = 0;
        if (stuck) return;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_bytes = nb;
        while (!bus.in_ready && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            n_vec++;
            n_err++;
            stuck = 1'b1;
            $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 400 cycles");
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_msg(input bit tail0);
        int  len;
        int  pos;
        int  nb;
        bit  lastw;
        len = msg.size();
        pos = 0;
        while (pos < len) begin
            nb    = (len - pos >= 4) ? 4 : (len - pos);
            lastw = (pos + nb == len) && !tail0;
            drive_word(pack_word(pos, nb), lastw,
                       lastw ? 3'(nb) : 3'($urandom_range(0, 7)));
            pos += nb;
            while ($urandom_range(0, 99) < gap_pct) @(negedge clk);
        end
        if (tail0 || len == 0) drive_word($urandom, 1'b1, 3'd0);
    endtask

    task automatic collect();
        int   guard;
        bit   done;
        bit   prev_hold;
        blk_t held;
        blk_t b;
        guard     = 0;
        done      = 1'b0;
        prev_hold = 1'b0;
        held      = '{default: '0};
        rx_q.delete();
        while (!done && !stuck && guard < 3000) begin
            bus.blk_ready = ($urandom_range(0, 99) < ready_pct);
            if (bus.blk_valid) begin
                b.data  = bus.blk_data;
                b.first = bus.blk_first;
                b.last  = bus.blk_last;
                if (prev_hold) begin
                    chkw("hold_data", b.data, held.data);
                    chk32("hold_flags", {30'd0, b.first, b.last}, {30'd0, held.first, held.last});
                end
                if (bus.blk_ready) begin
                    rx_q.push_back(b);
                    prev_hold = 1'b0;
                    done      = b.last;
                end else begin
                    prev_hold = 1'b1;
                    held      = b;
                end
            end else begin
                if (prev_hold) chk32("hold_valid", 32'(bus.blk_valid), 32'd1);
                prev_hold = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        bus.blk_ready = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL blk_last_timeout: got %0d blocks, expected a blk_last block", rx_q.size());
        end
    endtask

    task automatic run_msg(input bit tail0);
        int n;
        build_model();
        fork
            send_msg(tail0);
            collect();
        join
        chk32("nblocks", 32'(rx_q.size()), 32'(exp_q.size()));
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chkw("blk_data", rx_q[i].data, exp_q[i].data);
            chk32("blk_flags", {30'd0, rx_q[i].first, rx_q[i].last},
                               {30'd0, exp_q[i].first, exp_q[i].last});
        end
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin : main
        int   cnt;
        bit   seen;
        blk_t snap;

        tbl[0]  = '{3,   1'b0, 1, 32'h0000_0018, 0, 0,  32'h0102_0380};
        tbl[1]  = '{0,   1'b1, 1, 32'h0000_0000, 0, 0,  32'h8000_0000};
        tbl[2]  = '{55,  1'b0, 1, 32'h0000_01B8, 0, 13, 32'h3536_3780};
        tbl[3]  = '{56,  1'b0, 2, 32'h0000_01C0, 0, 14, 32'h8000_0000};
        tbl[4]  = '{56,  1'b1, 2, 32'h0000_01C0, 0, 14, 32'h8000_0000};
        tbl[5]  = '{52,  1'b1, 1, 32'h0000_01A0, 0, 13, 32'h8000_0000};
        tbl[6]  = '{64,  1'b0, 2, 32'h0000_0200, 1, 0,  32'h8000_0000};
        tbl[7]  = '{60,  1'b0, 2, 32'h0000_01E0, 0, 15, 32'h8000_0000};
        tbl[8]  = '{63,  1'b0, 2, 32'h0000_01F8, 0, 15, 32'h3D3E_3F80};
        tbl[9]  = '{119, 1'b0, 2, 32'h0000_03B8, 1, 13, 32'h7576_7780};
        tbl[10] = '{120, 1'b0, 3, 32'h0000_03C0, 1, 14, 32'h8000_0000};
        tbl[11] = '{128, 1'b1, 3, 32'h0000_0400, 2, 0,  32'h8000_0000};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_bytes  = '0;
        bus.blk_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk32("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk32("rst_blk_valid", 32'(bus.blk_valid), 32'd0);
        chk32("rst_flags", {30'd0, bus.blk_first, bus.blk_last}, 32'd0);
        chkw("rst_blk_data", bus.blk_data, 512'd0);
        reset = 1'b0;
        @(negedge clk);
        chk32("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // "abc": latency from acceptance to blk_valid
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        build_model();
        drive_word(ABC_WORD, 1'b1, 3'd3);
        cnt = 0;
        while (!bus.blk_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk32("abc_latency", 32'(cnt), 32'd14);
        chk32("abc_word0", word_of(bus.blk_data, 0), 32'h6162_6380);
        chk32("abc_word15", word_of(bus.blk_data, 15), 32'h0000_0018);
        chkw("abc_block", bus.blk_data, exp_q[0].data);
        chk32("abc_flags", {30'd0, bus.blk_first, bus.blk_last}, 32'd3);
        bus.blk_ready = 1'b1;
        @(negedge clk);
        bus.blk_ready = 1'b0;
        chk32("abc_in_ready_after", 32'(bus.in_ready), 32'd1);
        chk32("abc_valid_after", 32'(bus.blk_valid), 32'd0);

        // 64-byte message with the core stalling on the data block
        msg.delete();
        for (int j = 0; j < 64; j++) msg.push_back(8'($urandom));
        build_model();
        gap_pct = 0;
        send_msg(1'b0);
        chk32("b64_valid", 32'(bus.blk_valid), 32'd1);
        chk32("b64_flags0", {30'd0, bus.blk_first, bus.blk_last}, 32'd2);
        chkw("b64_block0", bus.blk_data, exp_q[0].data);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk32("b64_stall_in_ready", 32'(bus.in_ready), 32'd0);
            chkw("b64_stall_data", bus.blk_data, exp_q[0].data);
        end
        bus.blk_ready = 1'b1;
        @(negedge clk);
        bus.blk_ready = 1'b0;
        cnt = 0;
        while (!bus.blk_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk32("b64_word0", word_of(bus.blk_data, 0), 32'h8000_0000);
        chk32("b64_word15", word_of(bus.blk_data, 15), 32'h0000_0200);
        chkw("b64_block1", bus.blk_data, exp_q[1].data);
        chk32("b64_flags1", {30'd0, bus.blk_first, bus.blk_last}, 32'd1);
        bus.blk_ready = 1'b1;
        @(negedge clk);
        bus.blk_ready = 1'b0;

        // Reset while padding (slot 7): nothing may be emitted
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        drive_word(ABC_WORD, 1'b1, 3'd3);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk32("midrst_valid", 32'(bus.blk_valid), 32'd0);
        reset = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.blk_valid) seen = 1'b1;
        end
        chk32("midrst_no_block", 32'(seen), 32'd0);
        chk32("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        ready_pct = 100;
        run_msg(1'b0);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            msg.delete();
            for (int j = 0; j < tbl[i].len; j++) msg.push_back(8'(j + 1));
            ready_pct = 70;
            gap_pct   = 20;
            run_msg(tbl[i].tail0);
            chk32("tbl_nblk", 32'(rx_q.size()), 32'(tbl[i].nblk));
            if (rx_q.size() == tbl[i].nblk) begin
                snap = rx_q[tbl[i].nblk - 1];
                chk32("tbl_len_word", word_of(snap.data, 15), tbl[i].w15);
                chk32("tbl_chk_word", word_of(rx_q[tbl[i].cblk].data, tbl[i].cword), tbl[i].cval);
            end
        end

        // Random messages
        for (int m = 0; m < 40; m++) begin
            int len;
            bit t0;
            len = $urandom_range(0, 200);
            msg.delete();
            for (int j = 0; j < len; j++) msg.push_back(8'($urandom));
            t0 = (len == 0) || ((len % 4 == 0) && ($urandom_range(0, 1) == 1));
            ready_pct = $urandom_range(30, 100);
            gap_pct   = $urandom_range(0, 50);
            run_msg(t0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sha256_padder.md
# sha256_padder

Message padder and block builder directly upstream of the SHA-256 compression core. Accepts an arbitrary-length byte message as a stream of 32-bit words. Applies FIPS 180-4 padding: a 0x80 marker, zero fill, and a 64-bit big-endian bit length. Emits 512-bit blocks over a valid/ready handshake, with first/last flags so the core knows when to reload H0..H7 and when a digest is final.

## Interface
- No parameters; block size fixed at 512 bits, length field fixed at 64 bits.
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  padder can accept a word
- in_data  in  32  message word; first message byte in [31:24]
- in_last  in  1  word is the final word of the message
- in_bytes  in  3  valid bytes in word, 1..4; 0 legal only with in_last (empty tail); ignored (treated as 4) when in_last=0
- blk_valid  out  1  blk_data holds a complete block
- blk_ready  in  1  core accepts the block (core `start`)
- blk_data  out  512  block; word 0 in [511:480], first byte in [511:504]
- blk_first  out  1  block is the first of its message
- blk_last  out  1  block is the final (length-bearing) block

## Operation
- States: FILL, FULL, PAD, LEN, OUT.
- Word slot index widx is 0..15. Byte counter is 61 bits and wraps modulo 2^61. Bit length = byte count << 3, 64 bits.
- FILL: in_ready=1. On in_valid&&in_ready, write the word into slot widx and add in_bytes to the byte count.
  - Bytes beyond in_bytes are forced to 0.
  - in_last with in_bytes<4: place 0x80 immediately after the last valid byte, in the same word.
  - in_last with in_bytes=4: set marker_pending.
  - in_bytes=0: write nothing and leave widx unchanged; marker_pending=1.
- FILL exits:
  - Non-last word in slot 15 → FULL.
  - Last word in slot 15 → FULL, then PAD from slot 0.
  - Last word in any other slot → PAD at widx+1, or at widx when in_bytes=0.
- PAD: each cycle writes slot widx with 0x80000000 if marker_pending (then clears it), else 0.
  - widx≤12: widx++.
  - widx=13: → LEN.
  - widx=14: widx++.
  - widx=15: → FULL with blk_last=0, then return to PAD at widx=0.
- LEN: in one cycle, slot14 = length[63:32] and slot15 = length[31:0] → OUT.
- FULL/OUT:
  - blk_valid=1 and in_ready=0; blk_data and flags are held stable until blk_valid&&blk_ready.
  - FULL → FILL, or → PAD if padding is in progress.
  - OUT → FILL; byte counter and widx clear, blk_first re-arms.
- blk_first=1 only on the first emitted block of each message. blk_last=1 only in OUT.
- Slots not written in the current block read as 0, because the buffer clears on each handshake.

## Timing
- Reset values: in_ready=0 during reset and 1 the cycle after; blk_valid=0, blk_first=0, blk_last=0, blk_data=0. State=FILL, widx=0, count=0, marker_pending=0.
- Reset mid-operation discards any partial or pending block; blk_valid=0 the cycle after reset is sampled.
- 16th non-last word accepted at edge E → blk_valid=1 after E.
- Last word accepted in slot k≤12 at edge E → blk_valid=1 after edge E+(14−k).
  - Example: a 3-byte message in slot 0 → valid after E+14.
- Handshake edge → in_ready=1 the next cycle in FILL. Minimum throughput is 17 cycles per full block.
- blk_ready is ignored when blk_valid=0. in_valid is ignored outside FILL.
- A block handshake and a reset on the same edge: reset wins; the block counts as transferred to the core, and the padder discards its state.

## Configuration
- SHA256_PAD_BYTESWAP_EN defined: in_data is byte-reversed before any other processing. The first message byte is then in_data[7:0], and partial-word valid bytes count from [7:0] upward.
- Undefined: in_data is used as-is (big-endian; first byte in [31:24]).
- blk_data ordering is identical in both builds.

## Test plan
- "abc" as one word 0x61626300, in_bytes=3, in_last → one block: word0=0x61626380, words 1–14 = 0, word15=0x00000018; blk_first=blk_last=1; blk_valid 14 edges after acceptance.
- Empty message (in_bytes=0, in_last) → one block: word0=0x80000000, remaining words 0, length 0.
- 55-byte message → one block: word13[7:0]=0x80, length 0x1B8. 56-byte message → two blocks: first has word14=0x80000000 and blk_last=0; second is all zero except word15=0x1C0, with blk_first=0 and blk_last=1.
- 64-byte message → data block (first=1, last=0), then a block with word0=0x80000000 and word15=0x200. Hold blk_ready=0 for 10 cycles: blk_data stable, in_ready=0.
- Reset asserted while in PAD at widx=7 → blk_valid never rises. A following "abc" produces the correct single block with blk_first=1.
- SHA256_PAD_BYTESWAP_EN build: in_data=0x00636261, in_bytes=3, in_last → word0=0x61626380.
